ex_stage: RTL and testbench

Execute stage of the 5-stage MIPS pipeline: the consumer of the ID/EX pipeline register. It selects the ALU operands (ALUSrc) and destination register (RegDst), decodes ALUOp/funct, and performs single-cycle ALU operations or iterative 32-cycle multiply/divide. Results are registered into the EX/MEM-facing outputs. While an iterative operation runs, `stall_EX` holds ID/EX and the upstream stages.

---
 rtl/ex_stage.sv | 165 ++++++++++++++++
 tb/tb_ex_stage.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_stage.sv
// MIPS execute stage: operand/destination select, single-cycle ALU ops and
// 32-iteration shift-add multiply / restoring divide with a stall handshake.
//
// state | meaning
// IDLE  | accepting one ID/EX entry per cycle
// BUSY  | iterating mult/div, ID/EX held via stall_EX
module ex_stage (
    input  logic        clk_EX,
    input  logic        rst_EX,
    input  logic        valid_EX,
    input  logic [31:0] data1_EX,
    input  logic [31:0] data2_EX,
    input  logic [31:0] imm_EX,
    input  logic [4:0]  rd_EX,
    input  logic [4:0]  rt_EX,
    input  logic [7:0]  nextIns_EX,
    input  logic [1:0]  wb_EX,
    input  logic [2:0]  m_EX,
    input  logic        RegDst_EX,
    input  logic        ALUOp_EX,
    input  logic        ALUSrc_EX,
    output logic        stall_EX,
    output logic        valid_out_EX,
    output logic [31:0] result_EX,
    output logic [31:0] storeData_EX,
    output logic [4:0]  dest_EX,
    output logic [7:0]  branchTgt_EX,
    output logic        zero_EX,
    output logic [1:0]  wbOut_EX,
    output logic [2:0]  mOut_EX
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state, stateNext;
    logic [4:0]  iterCnt;
    logic        divMode;
    logic [31:0] opA, opB;
    logic [32:0] part;
    logic [1:0]  pendWb;
    logic [2:0]  pendM;

    logic [31:0] operandB, aluRes;
    logic [5:0]  funct;
    logic        startMul, startDiv;
    logic [31:0] stepA, stepB;
    logic [32:0] stepP, remShift;

    assign operandB = ALUSrc_EX ? imm_EX : data2_EX;
    assign funct    = imm_EX[5:0];
    assign stall_EX = (state == BUSY);

    always_comb begin
        aluRes   = 32'd0;
        startMul = 1'b0;
        startDiv = 1'b0;
        if (!ALUOp_EX) begin
            aluRes = data1_EX + operandB;
        end else begin
            case (funct)
                6'h20:   aluRes = data1_EX + operandB;
                6'h22:   aluRes = data1_EX - operandB;
                6'h24:   aluRes = data1_EX & operandB;
                6'h25:   aluRes = data1_EX | operandB;
                6'h2A:   aluRes = {31'd0, $signed(data1_EX) < $signed(operandB)};
                6'h18:   startMul = 1'b1;
                6'h1A:   startDiv = 1'b1;
                default: aluRes = 32'd0;
            endcase
        end
    end

    // mult: opA = shifted multiplicand, opB = multiplier, part = product
    // div:  opA = divisor, opB = dividend shifting into quotient, part = remainder
    always_comb begin
        stepA    = opA;
        stepB    = opB;
        stepP    = part;
        remShift = 33'd0;
        if (divMode) begin
            remShift = {part[31:0], opB[31]};
            if (remShift >= {1'b0, opA}) begin
                stepP = remShift - {1'b0, opA};
                stepB = {opB[30:0], 1'b1};
            end else begin
                stepP = remShift;
                stepB = {opB[30:0], 1'b0};
            end
        end else begin
            stepP = {1'b0, part[31:0] + (opB[0] ? opA : 32'd0)};
            stepA = {opA[30:0], 1'b0};
            stepB = {1'b0, opB[31:1]};
        end
    end

    always_ff @(posedge clk_EX) begin
        if (rst_EX) state <= IDLE;
        else        state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (valid_EX && (startMul || startDiv)) stateNext = BUSY;
            BUSY:    if (iterCnt == 5'd31) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk_EX) begin
        if (rst_EX) begin
            iterCnt      <= 5'd0;
            divMode      <= 1'b0;
            opA          <= 32'd0;
            opB          <= 32'd0;
            part         <= 33'd0;
            pendWb       <= 2'd0;
            pendM        <= 3'd0;
            valid_out_EX <= 1'b0;
            result_EX    <= 32'd0;
            storeData_EX <= 32'd0;
            dest_EX      <= 5'd0;
            branchTgt_EX <= 8'd0;
            zero_EX      <= 1'b0;
            wbOut_EX     <= 2'd0;
            mOut_EX      <= 3'd0;
        end else if (state == IDLE) begin
            valid_out_EX <= 1'b0;
            wbOut_EX     <= 2'd0;
            mOut_EX      <= 3'd0;
            if (valid_EX) begin
                storeData_EX <= data2_EX;
                dest_EX      <= RegDst_EX ? rd_EX : rt_EX;
                branchTgt_EX <= nextIns_EX + imm_EX[7:0];
                zero_EX      <= (data1_EX == data2_EX);
                if (startMul || startDiv) begin
                    iterCnt <= 5'd0;
                    divMode <= startDiv;
                    opA     <= startDiv ? operandB : data1_EX;
                    opB     <= startDiv ? data1_EX : operandB;
                    part    <= 33'd0;
                    pendWb  <= wb_EX;
                    pendM   <= m_EX;
                end else begin
                    result_EX    <= aluRes;
                    valid_out_EX <= 1'b1;
                    wbOut_EX     <= wb_EX;
                    mOut_EX      <= m_EX;
                end
            end
        end else begin
            opA     <= stepA;
            opB     <= stepB;
            part    <= stepP;
            iterCnt <= iterCnt + 5'd1;
            if (iterCnt == 5'd31) begin
                result_EX    <= divMode ? stepB : stepP[31:0];
                valid_out_EX <= 1'b1;
                wbOut_EX     <= pendWb;
                mOut_EX      <= pendM;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: spec vector table, reset corner cases, and randomized
// instructions checked against an arithmetic reference model.
module tb_ex_stage;

    logic        clk_EX = 1'b0;
    logic        rst_EX;
    logic        valid_EX;
    logic [31:0] data1_EX, data2_EX, imm_EX;
    logic [4:0]  rd_EX, rt_EX;
    logic [7:0]  nextIns_EX;
    logic [1:0]  wb_EX;
    logic [2:0]  m_EX;
    logic        RegDst_EX, ALUOp_EX, ALUSrc_EX;
    logic        stall_EX, valid_out_EX, zero_EX;
    logic [31:0] result_EX, storeData_EX;
    logic [4:0]  dest_EX;
    logic [7:0]  branchTgt_EX;
    logic [1:0]  wbOut_EX;
    logic [2:0]  mOut_EX;

    int tests = 0;
    int fails = 0;

    logic [31:0] lastRes, lastStore;
    logic [4:0]  lastDest;
    logic [7:0]  lastBr;
    logic        lastZero;

    typedef struct {
        logic        valid;
        logic [31:0] d1, d2, imm;
        logic [4:0]  rd, rt;
        logic [7:0]  ni;
        logic [1:0]  wb;
        logic [2:0]  m;
        logic        regDst, aluOp, aluSrc;
        logic [31:0] expRes;
    } vec_t;

    ex_stage dut (
        .clk_EX(clk_EX), .rst_EX(rst_EX), .valid_EX(valid_EX),
        .data1_EX(data1_EX), .data2_EX(data2_EX), .imm_EX(imm_EX),
        .rd_EX(rd_EX), .rt_EX(rt_EX), .nextIns_EX(nextIns_EX),
        .wb_EX(wb_EX), .m_EX(m_EX), .RegDst_EX(RegDst_EX),
        .ALUOp_EX(ALUOp_EX), .ALUSrc_EX(ALUSrc_EX),
        .stall_EX(stall_EX), .valid_out_EX(valid_out_EX),
        .result_EX(result_EX), .storeData_EX(storeData_EX),
        .dest_EX(dest_EX), .branchTgt_EX(branchTgt_EX), .zero_EX(zero_EX),
        .wbOut_EX(wbOut_EX), .mOut_EX(mOut_EX)
    );

    always #5 clk_EX = ~clk_EX;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {iterative, result} straight from the instruction semantics
    function automatic logic [32:0] model(logic aluOp, logic [5:0] fn,
                                          logic [31:0] a, logic [31:0] b);
        if (!aluOp) return {1'b0, a + b};
        case (fn)
            6'h20:   return {1'b0, a + b};
            6'h22:   return {1'b0, a - b};
            6'h24:   return {1'b0, a & b};
            6'h25:   return {1'b0, a | b};
            6'h2A:   return {1'b0, 31'd0, ($signed(a) < $signed(b))};
            6'h18:   return {1'b1, a * b};
            6'h1A:   return {1'b1, (b == 32'd0) ? 32'hFFFF_FFFF : a / b};
            default: return {1'b0, 32'd0};
        endcase
    endfunction

    function automatic vec_t mk(logic valid, logic [31:0] d1, logic [31:0] d2,
                                logic [31:0] imm, logic [4:0] rd, logic [4:0] rt,
                                logic [7:0] ni, logic [1:0] wb, logic [2:0] m,
                                logic regDst, logic aluOp, logic aluSrc,
                                logic [31:0] expRes);
        vec_t v;
        v.valid = valid; v.d1 = d1; v.d2 = d2; v.imm = imm; v.rd = rd; v.rt = rt;
        v.ni = ni; v.wb = wb; v.m = m; v.regDst = regDst; v.aluOp = aluOp;
        v.aluSrc = aluSrc; v.expRes = expRes;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(vec_t v);
        valid_EX = v.valid; data1_EX = v.d1; data2_EX = v.d2; imm_EX = v.imm;
        rd_EX = v.rd; rt_EX = v.rt; nextIns_EX = v.ni; wb_EX = v.wb; m_EX = v.m;
        RegDst_EX = v.regDst; ALUOp_EX = v.aluOp; ALUSrc_EX = v.aluSrc;
    endtask

    task automatic tick();
        @(posedge clk_EX);
        #1;
    endtask

    task automatic checkOutputsZero(string tag);
        chk({tag, "_stall"}, 32'(stall_EX), 32'd0);
        chk({tag, "_valid"}, 32'(valid_out_EX), 32'd0);
        chk({tag, "_result"}, result_EX, 32'd0);
        chk({tag, "_store"}, storeData_EX, 32'd0);
        chk({tag, "_dest"}, 32'(dest_EX), 32'd0);
        chk({tag, "_br"}, 32'(branchTgt_EX), 32'd0);
        chk({tag, "_zero"}, 32'(zero_EX), 32'd0);
        chk({tag, "_wb"}, 32'(wbOut_EX), 32'd0);
        chk({tag, "_m"}, 32'(mOut_EX), 32'd0);
        lastRes = 0; lastStore = 0; lastDest = 0; lastBr = 0; lastZero = 0;
    endtask

    // Present one ID/EX entry and check what EX/MEM sees when it completes.
    task automatic runOne(vec_t v);
        logic [32:0] mr;
        logic [31:0] bOp;
        int n;
        drive(v);
        chk("stallAtAccept", 32'(stall_EX), 32'd0);
        bOp = v.aluSrc ? v.imm : v.d2;
        mr  = model(v.aluOp, v.imm[5:0], v.d1, bOp);
        tick();
        if (!v.valid) begin
            chk("bubbleValid", 32'(valid_out_EX), 32'd0);
            chk("bubbleWb", 32'(wbOut_EX), 32'd0);
            chk("bubbleM", 32'(mOut_EX), 32'd0);
            chk("bubbleResHold", result_EX, lastRes);
            chk("bubbleDestHold", 32'(dest_EX), 32'(lastDest));
            chk("bubbleStall", 32'(stall_EX), 32'd0);
        end else begin
            if (mr[32]) begin
                n = 0;
                while (stall_EX === 1'b1 && n < 40) begin
                    chk("busyValid", 32'(valid_out_EX), 32'd0);
                    chk("busyWbM", {27'd0, wbOut_EX, mOut_EX}, 32'd0);
                    tick();
                    n++;
                end
                chk("stallCycles", 32'(n), 32'd32);
            end
            chk("stallAfter", 32'(stall_EX), 32'd0);
            chk("validOut", 32'(valid_out_EX), 32'd1);
            chk("result", result_EX, v.expRes);
            chk("modelResult", result_EX, mr[31:0]);
            chk("dest", 32'(dest_EX), 32'(v.regDst ? v.rd : v.rt));
            chk("branchTgt", 32'(branchTgt_EX), 32'(8'(v.ni + v.imm[7:0])));
            chk("zero", 32'(zero_EX), 32'(v.d1 == v.d2));
            chk("storeData", storeData_EX, v.d2);
            chk("wbOut", 32'(wbOut_EX), 32'(v.wb));
            chk("mOut", 32'(mOut_EX), 32'(v.m));
            lastRes = mr[31:0]; lastStore = v.d2;
            lastDest = v.regDst ? v.rd : v.rt;
            lastBr = v.ni + v.imm[7:0]; lastZero = (v.d1 == v.d2);
        end
    endtask

    vec_t tbl[15];
    vec_t v;
    vec_t rv;

    initial begin
        tbl[0]  = mk(1, 32'hFFFF_FFFE, 32'd3, 32'h20, 5'd9, 5'd2, 8'h10, 2'b01, 3'b001, 1, 1, 0, 32'h0000_0001);
        tbl[1]  = mk(1, 32'hFFFF_FFFE, 32'd3, 32'h2A, 5'd9, 5'd2, 8'h10, 2'b10, 3'b100, 1, 1, 0, 32'h0000_0001);
        tbl[2]  = mk(1, 32'hFFFF_FFFE, 32'd3, 32'h22, 5'd9, 5'd2, 8'h10, 2'b11, 3'b000, 1, 1, 0, 32'hFFFF_FFFB);
        tbl[3]  = mk(1, 32'h100, 32'h55, 32'hFFFF_FFFC, 5'd7, 5'd4, 8'hFC, 2'b11, 3'b010, 0, 0, 1, 32'h0000_00FC);
        tbl[4]  = mk(0, 32'h1234, 32'h5678, 32'h20, 5'd1, 5'd1, 8'h00, 2'b11, 3'b111, 1, 1, 0, 32'h0);
        tbl[5]  = mk(1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h24, 5'd3, 5'd6, 8'h20, 2'b01, 3'b011, 1, 1, 0, 32'hF000_F000);
        tbl[6]  = mk(1, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h25, 5'd3, 5'd6, 8'h20, 2'b01, 3'b011, 0, 1, 0, 32'hFFF0_FFF0);
        tbl[7]  = mk(1, 32'hDEAD_BEEF, 32'h1, 32'h3F, 5'd31, 5'd0, 8'hFF, 2'b10, 3'b101, 1, 1, 0, 32'h0);
        tbl[8]  = mk(1, 32'd5, 32'hFFFF_FFFF, 32'h2A, 5'd8, 5'd0, 8'h01, 2'b01, 3'b000, 1, 1, 0, 32'h0);
        tbl[9]  = mk(1, 32'hFFFF_FFFF, 32'd1, 32'h0, 5'd2, 5'd12, 8'h40, 2'b01, 3'b000, 0, 0, 0, 32'h0);
        tbl[10] = mk(1, 32'h0001_0003, 32'h0002_0005, 32'h18, 5'd10, 5'd11, 8'h30, 2'b10, 3'b001, 1, 1, 0, 32'h000B_000F);
        tbl[11] = mk(1, 32'h7, 32'h7, 32'h20, 5'd13, 5'd14, 8'h34, 2'b01, 3'b010, 1, 1, 0, 32'h0000_000E);
        tbl[12] = mk(1, 32'd7, 32'd0, 32'h1A, 5'd15, 5'd1, 8'h38, 2'b11, 3'b100, 1, 1, 0, 32'hFFFF_FFFF);
        tbl[13] = mk(1, 32'd100, 32'd7, 32'h1A, 5'd16, 5'd1, 8'h3C, 2'b01, 3'b110, 1, 1, 0, 32'd14);
        tbl[14] = mk(0, 32'd1, 32'd1, 32'h0, 5'd0, 5'd0, 8'h00, 2'b11, 3'b111, 0, 0, 0, 32'h0);

        // reset with random inputs pending
        rst_EX = 1'b1;
        for (int i = 0; i < 2; i++) begin
            v = mk(1, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom), 8'($urandom),
                   2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 32'h0);
            drive(v);
            tick();
        end
        checkOutputsZero("reset");
        rst_EX = 1'b0;

        for (int i = 0; i < 15; i++) runOne(tbl[i]);

        // reset at iteration 10 of a multiply: no result pulse may escape
        drive(tbl[10]);
        tick();
        chk("midMulStall", 32'(stall_EX), 32'd1);
        repeat (10) tick();
        chk("midMulStill", 32'(stall_EX), 32'd1);
        rst_EX = 1'b1;
        tick();
        checkOutputsZero("midReset");
        rst_EX = 1'b0;
        v = tbl[14];
        drive(v);
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 40; i++) begin
                tick();
                if (valid_out_EX === 1'b1) pulses++;
            end
            chk("midResetNoPulse", 32'(pulses), 32'd0);
        end
        runOne(tbl[0]);

        // randomized instruction stream, back-to-back
        for (int i = 0; i < 250; i++) begin
            logic [5:0] fn;
            int pick;
            rv.valid  = ($urandom_range(0, 7) != 0);
            rv.aluOp  = ($urandom_range(0, 3) != 0);
            pick = $urandom_range(0, 11);
            case (pick)
                0, 1:    fn = 6'h20;
                2, 3:    fn = 6'h22;
                4:       fn = 6'h24;
                5:       fn = 6'h25;
                6, 7:    fn = 6'h2A;
                8:       fn = 6'($urandom);
                9:       fn = 6'h18;
                10:      fn = 6'h1A;
                default: fn = 6'h20;
            endcase
            rv.imm    = rv.aluOp ? {$urandom_range(0, 32'h3FF_FFFF), fn} : $urandom;
            rv.aluSrc = rv.aluOp ? 1'b0 : 1'($urandom);
            rv.d1     = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 300);
            rv.d2     = ($urandom_range(0, 1) != 0) ? $urandom : $urandom_range(0, 20);
            if ($urandom_range(0, 5) == 0) rv.d2 = rv.d1;
            rv.rd = 5'($urandom); rv.rt = 5'($urandom); rv.ni = 8'($urandom);
            rv.wb = 2'($urandom); rv.m = 3'($urandom); rv.regDst = 1'($urandom);
            rv.expRes = model(rv.aluOp, rv.imm[5:0], rv.d1, rv.aluSrc ? rv.imm : rv.d2);
            runOne(rv);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
